cache_cmd_sched: RTL and testbench
==================================

Name: cache_cmd_sched

Overview:
- Front-end scheduler between the trace-command source and the two L1 cache models (instruction cache, data cache).
- Accepts one trace command at a time (code n plus 32-bit address) and routes it to the owning cache.
- Broadcasts global commands (clear, print) to both caches in fixed order, waiting for each cache to finish.
- Keeps saturating hit/miss statistics per cache and a count of illegal command codes.

Parameters:
ADDR_W, 32, address width of trace commands and cache request address
CMD_W, 4, width of command code n
CNT_W, 32, width of each statistics counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  trace command available
cmd_ready  out  1  scheduler can accept a command
cmd_n  in  CMD_W  trace command code
cmd_add  in  ADDR_W  trace command address
ic_req  out  1  one-cycle request strobe to instruction cache
ic_n  out  CMD_W  command code to instruction cache
ic_add  out  ADDR_W  address to instruction cache
ic_done  in  1  instruction cache finished current request
ic_hit  in  1  I-cache hit, valid with ic_done
ic_miss  in  1  I-cache miss, valid with ic_done
dc_req, dc_n, dc_add, dc_done, dc_hit, dc_miss  same as ic_*, for the data cache
busy  out  1  command in flight (state != IDLE)
ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt  out  CNT_W  statistics
bad_cmd_cnt  out  CNT_W  count of dropped illegal codes

Behaviour:
- Command routing:
  - 0 (data read), 1 (data write), 4 (snoop) -> D-cache only.
  - 2 (instruction fetch) -> I-cache only.
  - 3 (invalidate) -> I-cache then D-cache.
  - 8 (reset/clear) and 9 (print) -> I-cache then D-cache.
  - All other codes are illegal: dropped, bad_cmd_cnt increments by 1, no cache request.
- FSM states: IDLE, ISS_I, WAIT_I, ISS_D, WAIT_D.
  - IDLE: cmd_ready=1. On cmd_valid, latch n/add. Go to ISS_I if the I-cache is a target, else ISS_D. An illegal code stays in IDLE.
  - ISS_x: x_req=1 for exactly one cycle, then WAIT_x.
  - WAIT_x: hold until x_done. Then go to ISS_D if the D-cache is still a target, else IDLE.
- x_n/x_add hold the latched command from ISS_x through WAIT_x. They read 0 otherwise.
- x_done is ignored in any state other than WAIT_x, including the ISS_x cycle.
- Timing: accept at cycle T -> x_req at T+1 -> earliest done at T+2 -> cmd_ready=1 at T+3. Back-to-back single-target commands therefore take 3 cycles minimum.
- Statistics:
  - Updated only on done for codes 0, 1, 2, never for 3, 4, 8, 9.
  - hit increments x_hit_cnt; miss increments x_miss_cnt.
  - If hit and miss are both high, count a miss only. If neither is high, count nothing.
- Code 8 clears all five counters on the cycle D-cache done is accepted. The clear takes precedence over any increment in that cycle.
- All counters saturate at all-ones with no wrap.
- Reset values: cmd_ready=0 while rst=1 and 1 the cycle after; busy=0; all req=0; all n/add=0; all counters=0; state=IDLE.
- Reset mid-operation aborts the in-flight command. No further req is issued for it. A late done after reset is ignored because the FSM is in IDLE.

Decomposition:
- Shared package cache_pkg:
  - ADDR typedef (bit[31:0]).
  - Command-code constants: READ=0, WRITE=1, INST_FETCH=2, INVALIDATE=3, SNOOP=4, RESET=8, PRINT=9.
  - FSM state enum.
  - Routing function mapping code to {to_i, to_d, legal}.
- Sub-module sat_counter (CNT_W, inc, clr, clr has priority), instantiated five times.

Test Plan:
- Reset sequence: rst high 2 cycles -> cmd_ready=1 cycle after release; all counters 0; busy=0.
- INST_FETCH 0xFACEB00B, ic_done+ic_hit 1 cycle after ic_req -> ic_req high one cycle with ic_add=0xFACEB00B; ic_hit_cnt=1; dc_req never asserted; cmd_ready high 3 cycles after accept.
- Fetches 0xDEADBEEF (miss) then 0x0BEEFA55 (miss), then READ 0x0BEEFA55 (dc hit) -> ic_miss_cnt=2, dc_hit_cnt=1, others unchanged.
- PRINT with ic_done delayed 5 cycles -> dc_req asserts only the cycle after ic_done; cmd_ready stays 0 throughout; no counter changes.
- Illegal code 6 and code 15 -> no req on either cache, bad_cmd_cnt=2, cmd_ready stays 1.
- RESET (8) after nonzero stats, plus rst asserted during WAIT_D of a later INVALIDATE -> counters zero after the D-cache done; FSM in IDLE after rst; a stray dc_done after rst changes nothing.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the cache command scheduler: address type, trace
// command codes, scheduler FSM states and the code-to-cache routing table.
package cache_pkg;

    typedef bit [31:0] ADDR;

    // Trace command codes
    localparam int unsigned READ       = 0;
    localparam int unsigned WRITE      = 1;
    localparam int unsigned INST_FETCH = 2;
    localparam int unsigned INVALIDATE = 3;
    localparam int unsigned SNOOP      = 4;
    localparam int unsigned RESET      = 8;
    localparam int unsigned PRINT      = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISS_I  = 3'd1,
        WAIT_I = 3'd2,
        ISS_D  = 3'd3,
        WAIT_D = 3'd4
    } state_e;

    typedef struct packed {
        logic to_i;
        logic to_d;
        logic legal;
    } route_t;

    // Which caches a command code visits; an illegal code visits neither.
    function automatic route_t route_of(input int unsigned code);
        route_t r;
        r = '0;
        case (code)
            READ, WRITE, SNOOP: begin
                r.to_d  = 1'b1;
                r.legal = 1'b1;
            end
            INST_FETCH: begin
                r.to_i  = 1'b1;
                r.legal = 1'b1;
            end
            INVALIDATE, RESET, PRINT: begin
                r.to_i  = 1'b1;
                r.to_d  = 1'b1;
                r.legal = 1'b1;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Only plain reads, writes and fetches contribute to hit/miss statistics.
    function automatic logic is_stat(input int unsigned code);
        return (code == READ) || (code == WRITE) || (code == INST_FETCH);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync active-high), inc (count enable), clr (clear, wins
// over inc), cnt (current value, sticks at all-ones).
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cache_cmd_sched.sv
// Scheduler between the trace-command source and the I/D L1 cache models.
// Accepts one command at a time, issues a one-cycle request to each target
// cache in I-then-D order, waits for each done, and keeps statistics.
// Ports:
//   clk, rst                          clock, sync active-high reset
//   cmd_valid/cmd_ready/cmd_n/cmd_add trace command handshake and payload
//   ic_req/ic_n/ic_add                request to I-cache (n/add 0 when idle)
//   ic_done/ic_hit/ic_miss            I-cache completion and outcome
//   dc_*                              same for the D-cache
//   busy                              a command is in flight
//   *_cnt                             saturating hit/miss/illegal counters
module cache_cmd_sched
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CMD_W  = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CMD_W-1:0]  cmd_n,
    input  logic [ADDR_W-1:0] cmd_add,
    output logic              ic_req,
    output logic [CMD_W-1:0]  ic_n,
    output logic [ADDR_W-1:0] ic_add,
    input  logic              ic_done,
    input  logic              ic_hit,
    input  logic              ic_miss,
    output logic              dc_req,
    output logic [CMD_W-1:0]  dc_n,
    output logic [ADDR_W-1:0] dc_add,
    input  logic              dc_done,
    input  logic              dc_hit,
    input  logic              dc_miss,
    output logic              busy,
    output logic [CNT_W-1:0]  ic_hit_cnt,
    output logic [CNT_W-1:0]  ic_miss_cnt,
    output logic [CNT_W-1:0]  dc_hit_cnt,
    output logic [CNT_W-1:0]  dc_miss_cnt,
    output logic [CNT_W-1:0]  bad_cmd_cnt
);

    state_e             state_q, state_d;
    logic [CMD_W-1:0]   n_q, n_d;
    logic [ADDR_W-1:0]  add_q, add_d;
    logic               bad_inc;
    logic               i_sel, d_sel;
    route_t             rt_in, rt_q;
    logic               unused_route;

    assign rt_in = route_of(32'(cmd_n));
    assign rt_q  = route_of(32'(n_q));
    assign unused_route = &{1'b0, rt_q.to_i, rt_q.legal};

    // Next-state: route new command, step through issue/wait per cache
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        add_d   = add_q;
        bad_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (rt_in.legal) begin
                        n_d     = cmd_n;
                        add_d   = cmd_add;
                        state_d = rt_in.to_i ? ISS_I : ISS_D;
                    end else begin
                        bad_inc = 1'b1;
                    end
                end
            end
            ISS_I:   state_d = WAIT_I;
            WAIT_I:  if (ic_done) state_d = rt_q.to_d ? ISS_D : IDLE;
            ISS_D:   state_d = WAIT_D;
            WAIT_D:  if (dc_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        i_sel = (state_d == ISS_I) || (state_d == WAIT_I);
        d_sel = (state_d == ISS_D) || (state_d == WAIT_D);
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            add_q     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            ic_req    <= 1'b0;
            ic_n      <= '0;
            ic_add    <= '0;
            dc_req    <= 1'b0;
            dc_n      <= '0;
            dc_add    <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            add_q     <= add_d;
            cmd_ready <= (state_d == IDLE);
            busy      <= (state_d != IDLE);
            ic_req    <= (state_d == ISS_I);
            ic_n      <= i_sel ? n_d : '0;
            ic_add    <= i_sel ? add_d : '0;
            dc_req    <= (state_d == ISS_D);
            dc_n      <= d_sel ? n_d : '0;
            dc_add    <= d_sel ? add_d : '0;
        end
    end

    // Statistics: miss wins when a cache reports both hit and miss
    logic i_fin, d_fin, stat, clr_all;
    assign i_fin   = (state_q == WAIT_I) && ic_done;
    assign d_fin   = (state_q == WAIT_D) && dc_done;
    assign stat    = is_stat(32'(n_q));
    assign clr_all = d_fin && (n_q == CMD_W'(RESET));

    sat_counter #(.CNT_W(CNT_W)) u_ic_hit (
        .clk(clk), .rst(rst), .clr(clr_all),
        .inc(i_fin && stat && ic_hit && !ic_miss), .cnt(ic_hit_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_ic_miss (
        .clk(clk), .rst(rst), .clr(clr_all),
        .inc(i_fin && stat && ic_miss), .cnt(ic_miss_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_dc_hit (
        .clk(clk), .rst(rst), .clr(clr_all),
        .inc(d_fin && stat && dc_hit && !dc_miss), .cnt(dc_hit_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_dc_miss (
        .clk(clk), .rst(rst), .clr(clr_all),
        .inc(d_fin && stat && dc_miss), .cnt(dc_miss_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_bad_cmd (
        .clk(clk), .rst(rst), .clr(clr_all),
        .inc(bad_inc), .cnt(bad_cmd_cnt));

endmodule

// File: tb/tb_cache_cmd_sched.sv
// Self-checking bench for cache_cmd_sched: directed scenarios plus a random
// command stream checked against a queue-free behavioural model.
module tb_cache_cmd_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_n;
    logic [31:0] cmd_add;
    logic        ic_req, dc_req;
    logic [3:0]  ic_n, dc_n;
    logic [31:0] ic_add, dc_add;
    logic        ic_done, ic_hit, ic_miss;
    logic        dc_done, dc_hit, dc_miss;
    logic        busy;
    logic [31:0] ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt;

    cache_cmd_sched dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n), .cmd_add(cmd_add),
        .ic_req(ic_req), .ic_n(ic_n), .ic_add(ic_add),
        .ic_done(ic_done), .ic_hit(ic_hit), .ic_miss(ic_miss),
        .dc_req(dc_req), .dc_n(dc_n), .dc_add(dc_add),
        .dc_done(dc_done), .dc_hit(dc_hit), .dc_miss(dc_miss),
        .busy(busy),
        .ic_hit_cnt(ic_hit_cnt), .ic_miss_cnt(ic_miss_cnt),
        .dc_hit_cnt(dc_hit_cnt), .dc_miss_cnt(dc_miss_cnt),
        .bad_cmd_cnt(bad_cmd_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference statistics
    logic [31:0] m_ich, m_icm, m_dch, m_dcm, m_bad;

    // Observations from the last run_cmd
    int obs_i_reqs, obs_d_reqs, obs_lat, obs_i_done_k, obs_d_req_k;
    int obs_hold_bad, obs_zero_bad, obs_busy_bad;

    function automatic logic [31:0] sat(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
    endfunction

    function automatic bit exp_i(input logic [3:0] n);
        return n inside {4'd2, 4'd3, 4'd8, 4'd9};
    endfunction

    function automatic bit exp_d(input logic [3:0] n);
        return n inside {4'd0, 4'd1, 4'd3, 4'd4, 4'd8, 4'd9};
    endfunction

    // Cycles from accept edge to the first cycle cmd_ready is high again
    function automatic int exp_lat(input logic [3:0] n, input int di, input int dd);
        if (exp_i(n) && exp_d(n)) return 3 + di + dd;
        if (exp_i(n)) return 2 + di;
        if (exp_d(n)) return 2 + dd;
        return 1;
    endfunction

    task automatic model_update(input logic [3:0] n, input logic ih, im, dh, dm);
        case (n)
            4'd2: begin
                if (im) m_icm = sat(m_icm);
                else if (ih) m_ich = sat(m_ich);
            end
            4'd0, 4'd1: begin
                if (dm) m_dcm = sat(m_dcm);
                else if (dh) m_dch = sat(m_dch);
            end
            4'd8: begin
                m_ich = 0; m_icm = 0; m_dch = 0; m_dcm = 0; m_bad = 0;
            end
            4'd3, 4'd4, 4'd9: ;
            default: m_bad = sat(m_bad);
        endcase
    endtask

    // Issue one command and play both caches; di/dd = cycles from req to done
    task automatic run_cmd(input logic [3:0] n, input logic [31:0] a,
                           input int di, input int dd,
                           input logic ih, im, dh, dm);
        int pi, pd, w;
        bit iact, dact;
        obs_i_reqs = 0; obs_d_reqs = 0; obs_lat = 0;
        obs_i_done_k = -10; obs_d_req_k = -10;
        obs_hold_bad = 0; obs_zero_bad = 0; obs_busy_bad = 0;
        pi = 0; pd = 0; iact = 0; dact = 0;
        w = 0;
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) return;
        cmd_valid = 1'b1; cmd_n = n; cmd_add = a;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_n = 4'd0; cmd_add = 32'd0;
        for (int k = 1; k < 300; k++) begin
            if (ic_done) iact = 0;
            if (dc_done) dact = 0;
            ic_done = 0; ic_hit = 0; ic_miss = 0;
            dc_done = 0; dc_hit = 0; dc_miss = 0;
            if (ic_req) begin obs_i_reqs++; iact = 1; pi = di; end
            if (dc_req) begin obs_d_reqs++; dact = 1; pd = dd; obs_d_req_k = k; end
            if (iact && (ic_n !== n || ic_add !== a)) obs_hold_bad++;
            if (!iact && (ic_n !== 4'd0 || ic_add !== 32'd0)) obs_zero_bad++;
            if (dact && (dc_n !== n || dc_add !== a)) obs_hold_bad++;
            if (!dact && (dc_n !== 4'd0 || dc_add !== 32'd0)) obs_zero_bad++;
            if (busy === cmd_ready) obs_busy_bad++;
            if (!ic_req && pi > 0) begin
                pi--;
                if (pi == 0) begin
                    ic_done = 1; ic_hit = ih; ic_miss = im; obs_i_done_k = k;
                end
            end
            if (!dc_req && pd > 0) begin
                pd--;
                if (pd == 0) begin dc_done = 1; dc_hit = dh; dc_miss = dm; end
            end
            if (cmd_ready && !iact && !dact && pi == 0 && pd == 0) begin
                obs_lat = k;
                break;
            end
            @(negedge clk);
        end
        ic_done = 0; ic_hit = 0; ic_miss = 0;
        dc_done = 0; dc_hit = 0; dc_miss = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready_low got %b exp 0", cmd_ready); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after got %b exp 1", cmd_ready); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++;
        if ({ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt} !== 160'd0)
            $display("FAIL reset_counters got %h %h %h %h %h exp 0", ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({ic_req, dc_req, ic_n, dc_n, ic_add, dc_add} !== 74'd0)
            $display("FAIL reset_cache_if got req %b%b n %h %h add %h %h exp 0", ic_req, dc_req, ic_n, dc_n, ic_add, dc_add);
        else pass_cnt++;
        m_ich = 0; m_icm = 0; m_dch = 0; m_dcm = 0; m_bad = 0;
    endtask

    task automatic test_inst_fetch();
        run_cmd(4'd2, 32'hFACE_B00B, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        model_update(4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        total_cnt++; if (obs_i_reqs !== 1) $display("FAIL fetch_ic_req got %0d exp 1", obs_i_reqs); else pass_cnt++;
        total_cnt++; if (obs_d_reqs !== 0) $display("FAIL fetch_dc_req got %0d exp 0", obs_d_reqs); else pass_cnt++;
        total_cnt++; if (obs_lat !== 3) $display("FAIL fetch_latency got %0d exp 3", obs_lat); else pass_cnt++;
        total_cnt++; if (obs_hold_bad !== 0) $display("FAIL fetch_ic_add got %0d bad cycles exp 0", obs_hold_bad); else pass_cnt++;
        total_cnt++; if (obs_zero_bad !== 0) $display("FAIL fetch_idle_zero got %0d bad cycles exp 0", obs_zero_bad); else pass_cnt++;
        total_cnt++; if (ic_hit_cnt !== m_ich) $display("FAIL fetch_hit_cnt got %0d exp %0d", ic_hit_cnt, m_ich); else pass_cnt++;
    endtask

    task automatic test_miss_seq();
        run_cmd(4'd2, 32'hDEAD_BEEF, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        model_update(4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cmd(4'd2, 32'h0BEE_FA55, 2, 1, 1'b1, 1'b1, 1'b0, 1'b0);
        model_update(4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cmd(4'd0, 32'h0BEE_FA55, 1, 3, 1'b0, 1'b0, 1'b1, 1'b0);
        model_update(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (ic_miss_cnt !== m_icm) $display("FAIL seq_ic_miss got %0d exp %0d", ic_miss_cnt, m_icm); else pass_cnt++;
        total_cnt++; if (dc_hit_cnt !== m_dch) $display("FAIL seq_dc_hit got %0d exp %0d", dc_hit_cnt, m_dch); else pass_cnt++;
        total_cnt++; if (ic_hit_cnt !== m_ich) $display("FAIL seq_ic_hit got %0d exp %0d", ic_hit_cnt, m_ich); else pass_cnt++;
        total_cnt++; if (dc_miss_cnt !== m_dcm) $display("FAIL seq_dc_miss got %0d exp %0d", dc_miss_cnt, m_dcm); else pass_cnt++;
        total_cnt++; if (obs_lat !== 5) $display("FAIL seq_read_latency got %0d exp 5", obs_lat); else pass_cnt++;
    endtask

    task automatic test_print();
        run_cmd(4'd9, 32'h1234_5678, 5, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        model_update(4'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        total_cnt++; if (obs_i_reqs !== 1 || obs_d_reqs !== 1)
            $display("FAIL print_reqs got ic %0d dc %0d exp 1 1", obs_i_reqs, obs_d_reqs); else pass_cnt++;
        total_cnt++; if (obs_d_req_k !== obs_i_done_k + 1)
            $display("FAIL print_dc_order got dc_req cycle %0d exp %0d", obs_d_req_k, obs_i_done_k + 1); else pass_cnt++;
        total_cnt++; if (obs_lat !== 9) $display("FAIL print_latency got %0d exp 9", obs_lat); else pass_cnt++;
        total_cnt++; if (obs_busy_bad !== 0) $display("FAIL print_busy_ready got %0d bad cycles exp 0", obs_busy_bad); else pass_cnt++;
        total_cnt++;
        if ({ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt} !== {m_ich, m_icm, m_dch, m_dcm})
            $display("FAIL print_counters got %0d %0d %0d %0d exp %0d %0d %0d %0d",
                     ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, m_ich, m_icm, m_dch, m_dcm);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int reqs;
        run_cmd(4'd6, 32'hAAAA_0006, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_update(4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        reqs = obs_i_reqs + obs_d_reqs;
        run_cmd(4'd15, 32'hAAAA_000F, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_update(4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
        reqs += obs_i_reqs + obs_d_reqs;
        @(negedge clk);
        total_cnt++; if (reqs !== 0) $display("FAIL illegal_reqs got %0d exp 0", reqs); else pass_cnt++;
        total_cnt++; if (bad_cmd_cnt !== m_bad) $display("FAIL illegal_cnt got %0d exp %0d", bad_cmd_cnt, m_bad); else pass_cnt++;
        total_cnt++; if (cmd_ready !== 1'b1 || obs_lat !== 1)
            $display("FAIL illegal_ready got %b lat %0d exp 1 lat 1", cmd_ready, obs_lat); else pass_cnt++;
    endtask

    task automatic test_clear_and_abort();
        int w, late_reqs;
        bit seen;
        run_cmd(4'd8, 32'h0, 2, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        model_update(4'd8, 1'b1, 1'b0, 1'b1, 1'b0);
        total_cnt++;
        if ({ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt} !== {m_ich, m_icm, m_dch, m_dcm, m_bad})
            $display("FAIL clear_counters got %0d %0d %0d %0d %0d exp 0", ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt);
        else pass_cnt++;
        run_cmd(4'd1, 32'h0000_0040, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        model_update(4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        total_cnt++; if (dc_hit_cnt !== m_dch) $display("FAIL clear_then_hit got %0d exp %0d", dc_hit_cnt, m_dch); else pass_cnt++;
        // INVALIDATE aborted by rst while waiting on the D-cache
        cmd_valid = 1'b1; cmd_n = 4'd3; cmd_add = 32'h0000_0080;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_n = 4'd0; cmd_add = 32'd0;
        seen = 0;
        for (w = 0; w < 10 && !seen; w++) begin
            if (ic_req) seen = 1; else @(negedge clk);
        end
        @(negedge clk);
        ic_done = 1'b1;
        @(negedge clk);
        ic_done = 1'b0;
        for (w = 0; w < 10 && !dc_req; w++) @(negedge clk);
        total_cnt++; if (!seen || dc_req !== 1'b1)
            $display("FAIL abort_reach_wait_d got ic %b dc_req %b exp 1 1", seen, dc_req); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ich = 0; m_icm = 0; m_dch = 0; m_dcm = 0; m_bad = 0;
        total_cnt++; if (busy !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL abort_rst_state got busy %b ready %b exp 0 0", busy, cmd_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL abort_ready_after got %b exp 1", cmd_ready); else pass_cnt++;
        late_reqs = 0;
        dc_done = 1'b1; dc_hit = 1'b1; ic_done = 1'b1; ic_miss = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ic_req || dc_req || busy) late_reqs++;
        end
        dc_done = 1'b0; dc_hit = 1'b0; ic_done = 1'b0; ic_miss = 1'b0;
        total_cnt++; if (late_reqs !== 0) $display("FAIL abort_stray_done_activity got %0d exp 0", late_reqs); else pass_cnt++;
        total_cnt++;
        if ({ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt} !== {m_ich, m_icm, m_dch, m_dcm, m_bad})
            $display("FAIL abort_counters got %0d %0d %0d %0d %0d exp 0", ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [3:0] legal_tbl [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};
        logic [3:0] bad_tbl [9]   = '{4'd5, 4'd6, 4'd7, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        logic [3:0] n;
        logic [31:0] a;
        logic ih, im, dh, dm;
        int di, dd;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) n = bad_tbl[$urandom_range(0, 8)];
            else n = legal_tbl[$urandom_range(0, 6)];
            a  = $urandom;
            di = $urandom_range(1, 4);
            dd = $urandom_range(1, 4);
            {ih, im, dh, dm} = 4'($urandom);
            run_cmd(n, a, di, dd, ih, im, dh, dm);
            model_update(n, ih, im, dh, dm);
            total_cnt++; if (obs_i_reqs !== int'(exp_i(n)) || obs_d_reqs !== int'(exp_d(n)))
                $display("FAIL rnd_reqs n=%0d got ic %0d dc %0d exp %0d %0d", n, obs_i_reqs, obs_d_reqs, exp_i(n), exp_d(n));
            else pass_cnt++;
            total_cnt++; if (obs_lat !== exp_lat(n, di, dd))
                $display("FAIL rnd_latency n=%0d got %0d exp %0d", n, obs_lat, exp_lat(n, di, dd)); else pass_cnt++;
            total_cnt++; if (obs_hold_bad + obs_zero_bad + obs_busy_bad !== 0)
                $display("FAIL rnd_if n=%0d got hold %0d zero %0d busy %0d exp 0", n, obs_hold_bad, obs_zero_bad, obs_busy_bad);
            else pass_cnt++;
            total_cnt++;
            if ({ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt} !== {m_ich, m_icm, m_dch, m_dcm, m_bad})
                $display("FAIL rnd_counters n=%0d got %0d %0d %0d %0d %0d exp %0d %0d %0d %0d %0d", n,
                         ic_hit_cnt, ic_miss_cnt, dc_hit_cnt, dc_miss_cnt, bad_cmd_cnt, m_ich, m_icm, m_dch, m_dcm, m_bad);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_n = 4'd0; cmd_add = 32'd0;
        ic_done = 1'b0; ic_hit = 1'b0; ic_miss = 1'b0;
        dc_done = 1'b0; dc_hit = 1'b0; dc_miss = 1'b0;
        test_reset();
        test_inst_fetch();
        test_miss_seq();
        test_print();
        test_illegal();
        test_clear_and_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
